bcrypt_job_ctrl: RTL and testbench
==================================

// Module: bcrypt_job_ctrl
// PURPOSE
//  Host-facing job controller directly upstream of the bcrypt core arbiter.
//  Turns host register writes into the arbiter's 32-bit go word, watches the arbiter's all_done word,
//  and reports busy/done/timeout status. Also measures job length in cycles and raises a level interrupt.
//  Sits between the processor slave-register bus and the arbiter; BRAM data paths are not touched.
// PARAMETERS
//  C_SLV_DWIDTH   32     register / go / all_done width
//  CLEAR_CYCLES   4      cycles go_word is held 0 before a run (min 2); arbiter re-inits and clears all_done
//  DONE_CODE      32'hFF all_done value meaning every core has stored its result
// PORTS
//  clk          in   1   single clock; all logic rising-edge
//  rst_n        in   1   asynchronous, active-low reset
//  reg_wr_en    in   1   host write strobe, one cycle per write
//  reg_rd_en    in   1   host read strobe, one cycle per read
//  reg_addr     in   2   word index: 0 CTRL, 1 STATUS, 2 CYCLES, 3 TMO_LIMIT
//  reg_wdata    in   32  write data
//  reg_rdata    out  32  read data, registered
//  reg_rd_valid out  1   pulses 1 cycle after reg_rd_en
//  go_word      out  32  to arbiter slv_reg0: 0 = hold/re-init, 1 = run
//  all_done     in   32  from arbiter; same clock domain, no synchroniser
//  irq          out  1   level interrupt: IRQ_EN & (done | timeout)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, go_word 0, irq 0, reg_rdata 0, reg_rd_valid 0, all regs 0.
//  CTRL (addr 0)
//   - bit0 START: write-1 pulse, reads 0. bit1 ABORT: write-1 pulse, reads 0. bit2 IRQ_EN: RW.
//  STATUS (addr 1)
//   - bit0 BUSY: RO. bit1 DONE and bit2 TIMEOUT: write-1-to-clear.
//  CYCLES (addr 2): RO, cycles spent in RUN for current/last job; saturates at 32'hFFFFFFFF.
//  TMO_LIMIT (addr 3): RW; 0 disables timeout.
//  Reads: reg_rdata/reg_rd_valid valid the cycle after reg_rd_en. Writes take effect on the strobe edge.
//  FSM
//   - IDLE: go_word 0, BUSY 0.
//     START -> CLEAR: clears DONE, TIMEOUT, CYCLES and loads clear counter = CLEAR_CYCLES-1.
//   - CLEAR: go_word 0, BUSY 1; counts down -> RUN at 0.
//   - RUN: go_word 1, BUSY 1, CYCLES++ each cycle.
//     all_done==DONE_CODE -> IDLE with DONE=1.
//     TMO_LIMIT!=0 && CYCLES+1==TMO_LIMIT -> IDLE with TIMEOUT=1.
//   - ABORT in CLEAR or RUN -> IDLE, no flag set, CYCLES frozen.
//  go_word drops to 0 on the edge leaving RUN; arbiter re-inits, results already in BRAM.
//  Edge cases
//   - START while BUSY ignored.
//   - START and ABORT in one write: ABORT wins, stays IDLE.
//   - all_done hit and timeout same cycle: DONE wins, TIMEOUT stays 0.
//   - ABORT and all_done hit same cycle: DONE set (completion wins).
//   - Host W1C of DONE in same cycle hardware sets it: hardware set wins.
//   - all_done values other than DONE_CODE ignored.
//   - CLEAR_CYCLES>=2 guarantees stale 0xFF is never sampled in RUN.
//   - rst_n low mid-run: go_word 0 immediately (async).
//  irq is combinational from registered flags and IRQ_EN: no extra latency; deasserts same cycle flags clear.
// STRUCTURE
//  bcrypt_pkg: register address localparams, CTRL/STATUS bit indices, FSM state encodings (IDLE/CLEAR/RUN),
//  DONE_CODE default. Single module, no sub-module. One 32-bit saturating counter, one small clear down-counter.
// TESTING
//  1 reset: rst_n low -> go_word=0, irq=0, reads of all 4 addrs return 0.
//  2 normal job: TMO_LIMIT=0, write CTRL=5, all_done=0xFF 100 cycles into RUN
//    -> go_word 0 for 4 cycles, then 1; STATUS=2, CYCLES=100 (+/-1 per edge rule), irq=1; W1C STATUS=2 -> irq=0.
//  3 timeout: TMO_LIMIT=50, START, all_done stays 0 -> after 50 RUN cycles STATUS=4, CYCLES=50, go_word=0.
//  4 collision: TMO_LIMIT=20, all_done=0xFF on RUN cycle 20 -> STATUS=2 (DONE only).
//  5 abort/ignore: START then START again in RUN -> no restart; ABORT -> STATUS=0, go_word=0 next cycle.
//  6 async reset mid-RUN: rst_n low -> go_word=0 before next clk edge; all registers 0 after release.

Source files
------------

// File: rtl/bcrypt_pkg.sv
// Shared definitions for the bcrypt job controller: register map, bit positions,
// FSM encoding and the arbiter's "all cores finished" code.
package bcrypt_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CYCLES = 2'd2;
  localparam logic [1:0] ADDR_TMO    = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_TMO  = 2;

  localparam logic [31:0] DONE_CODE_DEF = 32'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } job_state_t;

endpackage

// File: rtl/bcrypt_job_ctrl.sv
// Host-facing job controller: turns register writes into the arbiter go word,
// watches all_done, and reports busy/done/timeout, job length and a level irq.
module bcrypt_job_ctrl
  import bcrypt_pkg::*;
#(
  parameter int C_SLV_DWIDTH = 32,
  parameter int CLEAR_CYCLES = 4,
  parameter logic [C_SLV_DWIDTH-1:0] DONE_CODE = C_SLV_DWIDTH'(DONE_CODE_DEF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reg_wr_en,
  input  logic                    reg_rd_en,
  input  logic [1:0]              reg_addr,
  input  logic [C_SLV_DWIDTH-1:0] reg_wdata,
  output logic [C_SLV_DWIDTH-1:0] reg_rdata,
  output logic                    reg_rd_valid,
  output logic [C_SLV_DWIDTH-1:0] go_word,
  input  logic [C_SLV_DWIDTH-1:0] all_done,
  output logic                    irq
);

  localparam int W     = C_SLV_DWIDTH;
  localparam int CLR_W = (CLEAR_CYCLES > 2) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [W-1:0]     CYC_MAX  = '1;

  // Host bus: no back-pressure. A write lands on the edge its one-cycle strobe is
  // high; a read strobe yields reg_rdata with reg_rd_valid exactly one cycle later.
  job_state_t       state, state_nxt;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [W-1:0]     cycles, cycles_nxt;
  logic [W-1:0]     tmo_limit;
  logic             irq_en;
  logic             done_flag, done_nxt;
  logic             tmo_flag, tmo_nxt;
  logic [W-1:0]     rd_mux;

  logic wr_ctrl, wr_status, wr_tmo;
  logic start_req, abort_req, clr_done, clr_tmo;
  logic all_done_hit, tmo_hit;

  assign wr_ctrl   = reg_wr_en && (reg_addr == ADDR_CTRL);
  assign wr_status = reg_wr_en && (reg_addr == ADDR_STATUS);
  assign wr_tmo    = reg_wr_en && (reg_addr == ADDR_TMO);

  assign start_req = wr_ctrl && reg_wdata[CTRL_START];
  assign abort_req = wr_ctrl && reg_wdata[CTRL_ABORT];
  assign clr_done  = wr_status && reg_wdata[STAT_DONE];
  assign clr_tmo   = wr_status && reg_wdata[STAT_TMO];

  assign all_done_hit = (all_done == DONE_CODE);
  // Widened compare so a saturated counter never wraps into a false timeout.
  assign tmo_hit = (tmo_limit != '0) &&
                   (({1'b0, cycles} + (W+1)'(1)) == {1'b0, tmo_limit});

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    cycles_nxt  = cycles;
    done_nxt    = done_flag && !clr_done;
    tmo_nxt     = tmo_flag && !clr_tmo;
    case (state)
      ST_IDLE: begin
        if (start_req && !abort_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = CLR_LOAD;
          cycles_nxt  = '0;
          done_nxt    = 1'b0;
          tmo_nxt     = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (abort_req) begin
          state_nxt = ST_IDLE;
        end else if (clr_cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          clr_cnt_nxt = clr_cnt - CLR_W'(1);
        end
      end
      ST_RUN: begin
        if (cycles != CYC_MAX) cycles_nxt = cycles + W'(1);
        // Completion outranks abort, which outranks timeout.
        if (all_done_hit) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (abort_req) begin
          state_nxt = ST_IDLE;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          tmo_nxt   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      clr_cnt   <= '0;
      cycles    <= '0;
      done_flag <= 1'b0;
      tmo_flag  <= 1'b0;
      irq_en    <= 1'b0;
      tmo_limit <= '0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      cycles    <= cycles_nxt;
      done_flag <= done_nxt;
      tmo_flag  <= tmo_nxt;
      if (wr_ctrl) irq_en <= reg_wdata[CTRL_IRQ_EN];
      if (wr_tmo)  tmo_limit <= reg_wdata;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY] = (state != ST_IDLE);
        rd_mux[STAT_DONE] = done_flag;
        rd_mux[STAT_TMO]  = tmo_flag;
      end
      ADDR_CYCLES: rd_mux = cycles;
      ADDR_TMO:    rd_mux = tmo_limit;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_rdata    <= '0;
      reg_rd_valid <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      if (reg_rd_en) reg_rdata <= rd_mux;
    end
  end

  // Decoded straight from the state register, so reset drops go immediately.
  assign go_word = {{(W-1){1'b0}}, (state == ST_RUN)};
  assign irq     = irq_en && (done_flag || tmo_flag);

endmodule

// File: tb/tb_bcrypt_job_ctrl.sv
// Randomized bench for bcrypt_job_ctrl: each job's outcome (length, flag, go timing)
// is predicted from the job parameters and compared at every negedge.
module tb_bcrypt_job_ctrl;

  localparam int          CLR   = 4;
  localparam logic [31:0] DONE  = 32'hFF;
  localparam logic [1:0]  A_CTRL = 2'd0, A_STAT = 2'd1, A_CYC = 2'd2, A_TMO = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_wr_en, reg_rd_en;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata, go_word, all_done;
  logic        reg_rd_valid, irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bcrypt_job_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rd_valid(reg_rd_valid),
    .go_word(go_word), .all_done(all_done), .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end on a negedge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    reg_wr_en = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    reg_rd_en = 1'b1;
    reg_addr  = addr;
    @(negedge clk);
    reg_rd_en = 1'b0;
    check_eq({tag, "_valid"}, {31'b0, reg_rd_valid}, 32'd1);
    check_eq(tag, reg_rdata, exp_q.pop_front());
  endtask

  // Event cycles are RUN-cycle numbers (1 = first RUN cycle); 0 means never.
  // d: all_done hits DONE, a: ABORT write, s: stray START write, w: STATUS W1C write.
  task automatic run_job(input string tag, input int lim, input int d, input int a,
                         input int s, input int w, input bit ien);
    int endc;
    bit done_f, tmo_f;
    logic [31:0] v;
    endc = 1 << 30;
    if (d != 0) endc = d;
    if (a != 0 && a < endc) endc = a;
    if (lim != 0 && lim < endc) endc = lim;
    done_f = (d != 0) && (endc == d);
    tmo_f  = !done_f && (lim != 0) && (endc == lim) && !((a != 0) && (endc == a));

    bus_write(A_TMO, lim);
    bus_write(A_CTRL, {29'b0, ien, 2'b01});
    for (int i = 0; i < CLR; i++) begin
      check_eq({tag, "_clear_go"}, go_word, 32'd0);
      @(negedge clk);
    end
    for (int r = 1; r <= endc; r++) begin
      check_eq({tag, "_run_go"}, go_word, 32'd1);
      v = $urandom;
      if (v == DONE) v = 32'd0;
      all_done  = (r == d) ? DONE : v;
      reg_wr_en = 1'b0;
      if (r == a) begin
        reg_wr_en = 1'b1; reg_addr = A_CTRL; reg_wdata = {29'b0, ien, 2'b10};
      end else if (r == s) begin
        reg_wr_en = 1'b1; reg_addr = A_CTRL; reg_wdata = {29'b0, ien, 2'b01};
      end else if (r == w) begin
        reg_wr_en = 1'b1; reg_addr = A_STAT; reg_wdata = 32'h6;
      end
      @(negedge clk);
    end
    reg_wr_en = 1'b0;
    all_done  = 32'd0;
    check_eq({tag, "_end_go"}, go_word, 32'd0);
    check_eq({tag, "_irq"}, {31'b0, irq}, {31'b0, ien & (done_f | tmo_f)});
    bus_read({tag, "_status"}, A_STAT, {29'b0, tmo_f, done_f, 1'b0});
    bus_read({tag, "_cycles"}, A_CYC, endc);
    bus_read({tag, "_tmo"}, A_TMO, lim);
    bus_read({tag, "_ctrl"}, A_CTRL, {29'b0, ien, 2'b00});
    bus_write(A_STAT, 32'h6);
    check_eq({tag, "_irq_w1c"}, {31'b0, irq}, 32'd0);
    bus_read({tag, "_status_w1c"}, A_STAT, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim, d, a, s, endc;
    bit ien;
    rst_n = 1'b0; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_addr = 2'd0;
    reg_wdata = 32'd0; all_done = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_go", go_word, 32'd0);
    check_eq("rst_irq", {31'b0, irq}, 32'd0);
    check_eq("rst_rd_valid", {31'b0, reg_rd_valid}, 32'd0);
    check_eq("rst_rdata", reg_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read("rst_ctrl", A_CTRL, 32'd0);
    bus_read("rst_status", A_STAT, 32'd0);
    bus_read("rst_cycles", A_CYC, 32'd0);
    bus_read("rst_tmo", A_TMO, 32'd0);

    run_job("normal",    0, 100, 0,  0,  0,  1'b1);
    run_job("timeout",  50,   0, 0,  0,  0,  1'b0);
    run_job("collide",  20,  20, 0,  0,  0,  1'b1);
    run_job("restart",   0,   0, 30, 10, 0,  1'b0);
    run_job("abort_dn",  0,  15, 15, 0,  0,  1'b1);
    run_job("w1c_race",  0,  25, 0,  0,  25, 1'b1);
    run_job("tmo_irq",  12,   0, 0,  5,  0,  1'b1);

    // START and ABORT in one write must leave the controller idle.
    bus_write(A_CTRL, 32'h3);
    for (int i = 0; i < CLR + 2; i++) begin
      check_eq("st_ab_go", go_word, 32'd0);
      @(negedge clk);
    end
    bus_read("st_ab_status", A_STAT, 32'd0);

    for (int j = 0; j < 25; j++) begin
      lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 60));
      d   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 70));
      a   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 70)) : 0;
      if (lim == 0 && d == 0 && a == 0) d = $urandom_range(1, 70);
      if (a != 0 && a == lim) a = a + 1;
      endc = 1 << 30;
      if (d != 0) endc = d;
      if (a != 0 && a < endc) endc = a;
      if (lim != 0 && lim < endc) endc = lim;
      s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, endc)) : 0;
      if (s == a) s = 0;
      ien = 1'($urandom_range(0, 1));
      run_job("rand", lim, d, a, s, 0, ien);
    end

    // Async reset in the middle of RUN.
    bus_write(A_TMO, 32'd1000);
    bus_write(A_CTRL, 32'h5);
    repeat (CLR + 10) @(negedge clk);
    check_eq("arst_pre_go", go_word, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_go", go_word, 32'd0);
    check_eq("arst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_idle_go", go_word, 32'd0);
    bus_read("arst_ctrl", A_CTRL, 32'd0);
    bus_read("arst_status", A_STAT, 32'd0);
    bus_read("arst_cycles", A_CYC, 32'd0);
    bus_read("arst_tmo", A_TMO, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
